bus_reg_bank: RTL

BUS_REG_BANK -- requirements
Module: bus_reg_bank

---
 rtl/bus_reg_bank.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bus_reg_bank.sv
// Small register bank driven by a one-command-per-cycle bus: load/move/arith/shift,
// a two-cycle SWAP, a registered READ port and a combinational peek port.
module bus_reg_bank #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 2
) (
   input  logic              clock,
   input  logic              clear,
   input  logic              en,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        op,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   input  logic [WIDTH-1:0]  din,
   output logic [WIDTH-1:0]  dout,
   output logic              dout_valid,
   output logic              carry,
   output logic              zero,
   input  logic [ADDR_W-1:0] peek_addr,
   output logic [WIDTH-1:0]  peek_data
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic {IDLE, SWAP2} state_t;
   typedef enum logic [2:0] {
      OP_NOP  = 3'b000,
      OP_LOAD = 3'b001,
      OP_MOVE = 3'b010,
      OP_ADD  = 3'b011,
      OP_INC  = 3'b100,
      OP_SHR  = 3'b101,
      OP_SWAP = 3'b110,
      OP_READ = 3'b111
   } opcode_t;

   state_t              state, state_nxt;
   logic [WIDTH-1:0]    regs [DEPTH];
   logic [WIDTH-1:0]    tmp;
   logic [ADDR_W-1:0]   dst_q;

   logic                accept;
   logic                we;
   logic [ADDR_W-1:0]   waddr;
   logic [WIDTH-1:0]    wdata;
   logic                carry_set, carry_nxt;
   logic                zero_set;
   logic                rd_load;
   logic                tmp_load;
   logic [WIDTH:0]      sum;

   assign cmd_ready = (state == IDLE);
   assign accept    = cmd_valid & cmd_ready & en;
   assign peek_data = regs[peek_addr];

   // Single write port: the first SWAP cycle writes reg[src], the second writes reg[dst_q].
   always_comb begin
      state_nxt = state;
      we        = 1'b0;
      waddr     = dst;
      wdata     = '0;
      carry_set = 1'b0;
      carry_nxt = carry;
      zero_set  = 1'b0;
      rd_load   = 1'b0;
      tmp_load  = 1'b0;
      sum       = '0;
      case (state)
         IDLE: begin
            if (accept) begin
               case (opcode_t'(op))
                  OP_LOAD: begin
                     we = 1'b1; wdata = din; zero_set = 1'b1;
                  end
                  OP_MOVE: begin
                     we = 1'b1; wdata = regs[src]; zero_set = 1'b1;
                  end
                  OP_ADD: begin
                     sum = {1'b0, regs[dst]} + {1'b0, regs[src]};
                     we = 1'b1; wdata = sum[WIDTH-1:0]; zero_set = 1'b1;
                     carry_set = 1'b1; carry_nxt = sum[WIDTH];
                  end
                  OP_INC: begin
                     sum = {1'b0, regs[dst]} + (WIDTH+1)'(1);
                     we = 1'b1; wdata = sum[WIDTH-1:0]; zero_set = 1'b1;
                     carry_set = 1'b1; carry_nxt = sum[WIDTH];
                  end
                  OP_SHR: begin
                     we = 1'b1; wdata = regs[dst] >> 1; zero_set = 1'b1;
                     carry_set = 1'b1; carry_nxt = regs[dst][0];
                  end
                  OP_SWAP: begin
                     we = 1'b1; waddr = src; wdata = regs[dst];
                     tmp_load = 1'b1; state_nxt = SWAP2;
                  end
                  OP_READ: rd_load = 1'b1;
                  default: ;
               endcase
            end
         end
         SWAP2: begin
            if (en) begin
               we = 1'b1; waddr = dst_q; wdata = tmp; state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state      <= IDLE;
         for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
         tmp        <= '0;
         dst_q      <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         carry      <= 1'b0;
         zero       <= 1'b0;
      end else begin
         state      <= state_nxt;
         dout_valid <= rd_load;
         if (we)        regs[waddr] <= wdata;
         if (tmp_load) begin
            tmp   <= regs[src];
            dst_q <= dst;
         end
         if (rd_load)   dout  <= regs[src];
         if (carry_set) carry <= carry_nxt;
         if (zero_set)  zero  <= (wdata == '0);
      end
   end

endmodule
